alu_op_stage: RTL and testbench

//  Operand/flag staging stage wrapped around the 16-bit alu. Captures operands A/B from the

---
 rtl/alu_op_stage.sv | 141 ++++++++++++++
 tb/tb_alu_op_stage.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_stage.sv
// Operand/flag staging stage around a 16-bit ALU.
// Latches operands from a shared bus while idle, drives the ALU for EXEC_CYCLES cycles,
// then registers the result and carry/zero flags and pulses result_valid for one cycle.
module alu_op_stage #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned SEL_W       = 5,
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] bus_in,
  input  logic             load_a,
  input  logic             load_b,
  input  logic             op_valid,
  input  logic [SEL_W-1:0] op_sel,
  input  logic             use_carry,
  input  logic             clear_flags,
  output logic             op_ready,
  output logic [WIDTH-1:0] in_1,
  output logic [WIDTH-1:0] in_2,
  output logic [SEL_W-1:0] select,
  output logic             enable,
  output logic             carry_in,
  input  logic [WIDTH-1:0] alu_data,
  input  logic             alu_carry,
  input  logic             alu_zero,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             flag_c,
  output logic             flag_z
);

  localparam int unsigned CntW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(EXEC_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] in_1_q, in_1_d;
  logic [WIDTH-1:0] in_2_q, in_2_d;
  logic [SEL_W-1:0] select_q, select_d;
  logic             carry_in_q, carry_in_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             flag_c_q, flag_c_d;
  logic             flag_z_q, flag_z_d;
  logic             capture;

  // Next-state: operand/opcode capture in idle, execute countdown, result/flag capture.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    in_1_d     = in_1_q;
    in_2_d     = in_2_q;
    select_d   = select_q;
    carry_in_d = carry_in_q;
    result_d   = result_q;
    capture    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (load_a) in_1_d = bus_in;
        if (load_b) in_2_d = bus_in;
        if (op_valid) begin
          select_d   = op_sel;
          // Uses the flag as it stands before any same-cycle clear_flags.
          carry_in_d = use_carry & flag_c_q;
          cnt_d      = CntLoad;
          state_d    = StExec;
        end
      end
      StExec: begin
        if (cnt_q == '0) begin
          result_d = alu_data;
          capture  = 1'b1;
          state_d  = StDone;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // A capture on the same edge as clear_flags takes priority.
    if (capture) begin
      flag_c_d = alu_carry;
      flag_z_d = alu_zero;
    end else if (clear_flags) begin
      flag_c_d = 1'b0;
      flag_z_d = 1'b0;
    end else begin
      flag_c_d = flag_c_q;
      flag_z_d = flag_z_q;
    end
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      in_1_q     <= '0;
      in_2_q     <= '0;
      select_q   <= '0;
      carry_in_q <= 1'b0;
      result_q   <= '0;
      flag_c_q   <= 1'b0;
      flag_z_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      in_1_q     <= in_1_d;
      in_2_q     <= in_2_d;
      select_q   <= select_d;
      carry_in_q <= carry_in_d;
      result_q   <= result_d;
      flag_c_q   <= flag_c_d;
      flag_z_q   <= flag_z_d;
    end
  end

  // Outputs decoded from registered state; op_ready stays low while reset is held.
  always_comb begin
    op_ready     = (state_q == StIdle) & rst_n;
    enable       = (state_q == StExec);
    result_valid = (state_q == StDone);
    in_1         = in_1_q;
    in_2         = in_2_q;
    select       = select_q;
    carry_in     = carry_in_q;
    result       = result_q;
    flag_c       = flag_c_q;
    flag_z       = flag_z_q;
  end

endmodule

// File: tb/tb_alu_op_stage.sv
// Scoreboard bench for alu_op_stage: driver pushes expected operations, monitor checks
// ALU drive during execute and the registered result/flags on each result_valid pulse.
module tb_alu_op_stage;

  localparam int unsigned W  = 16;
  localparam int unsigned S  = 5;
  localparam int unsigned Ec = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [W-1:0] bus_in = '0;
  logic         load_a = 1'b0, load_b = 1'b0, op_valid = 1'b0;
  logic [S-1:0] op_sel = '0;
  logic         use_carry = 1'b0, clear_flags = 1'b0;
  logic         op_ready, enable, carry_in, result_valid, flag_c, flag_z;
  logic [W-1:0] in_1, in_2, result, alu_data;
  logic [S-1:0] select;
  logic         alu_carry, alu_zero;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [W-1:0] a, b, res;
    logic [S-1:0] sel;
    logic         cin, c, z;
  } exp_t;
  exp_t sb[$];

  // Reference state: operands and flags as the specification says they should be.
  logic [W-1:0] m_a = '0, m_b = '0;
  logic         m_c = 1'b0, m_z = 1'b0;

  alu_op_stage #(.WIDTH(W), .SEL_W(S), .EXEC_CYCLES(Ec)) dut (
    .clk(clk), .rst_n(rst_n), .bus_in(bus_in), .load_a(load_a), .load_b(load_b),
    .op_valid(op_valid), .op_sel(op_sel), .use_carry(use_carry), .clear_flags(clear_flags),
    .op_ready(op_ready), .in_1(in_1), .in_2(in_2), .select(select), .enable(enable),
    .carry_in(carry_in), .alu_data(alu_data), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .result(result), .result_valid(result_valid), .flag_c(flag_c), .flag_z(flag_z)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // ALU behaviour: returns {carry, zero, data}.
  function automatic logic [W+1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [S-1:0] sel, input logic cin);
    logic [W:0] t;
    case (sel)
      5'd0:    t = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
      5'd1:    t = {1'b0, a} - {1'b0, b} - (W+1)'(cin);
      5'd2:    t = {1'b0, a & b};
      5'd3:    t = {1'b0, a | b};
      default: t = {1'b0, a ^ b};
    endcase
    return {t[W], (t[W-1:0] == '0), t[W-1:0]};
  endfunction

  // ALU stub: real answer while enabled, junk otherwise so mistimed capture shows up.
  logic [W-1:0] noise = 16'h5a3c;
  logic [W+1:0] alu_o;
  always @(posedge clk) noise <= W'($urandom);
  always_comb alu_o = alu_fn(in_1, in_2, select, carry_in);
  assign alu_data  = enable ? alu_o[W-1:0] : noise;
  assign alu_carry = enable ? alu_o[W+1] : noise[0];
  assign alu_zero  = enable ? alu_o[W] : noise[1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: checks operands during execute and results on each result_valid pulse.
  int run = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      run = 0;
    end else begin
      if (enable) begin
        run++;
        check("exec_not_ready", {63'd0, op_ready}, 64'd0);
        if (sb.size() == 0) check("enable_without_op", 64'd1, 64'd0);
        else check("exec_operands", {26'd0, in_1, in_2, select, carry_in},
                   {26'd0, sb[0].a, sb[0].b, sb[0].sel, sb[0].cin});
      end
      if (result_valid) begin
        check("valid_with_enable", {63'd0, enable}, 64'd0);
        check("exec_length", 64'(run), 64'(Ec));
        run = 0;
        if (sb.size() == 0) begin
          check("unexpected_result", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("result_flags", {46'd0, result, flag_c, flag_z}, {46'd0, e.res, e.c, e.z});
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!op_ready && n < 50);
    if (!op_ready) check("ready_timeout", 64'd0, 64'd1);
  endtask

  // One idle cycle of loads and/or clear; call only at posedge+1.
  task automatic idle_cycle(input logic la, input logic lb, input logic [W-1:0] val,
                            input logic clr);
    wait_ready();
    load_a = la; load_b = lb; bus_in = val; clear_flags = clr;
    @(posedge clk);
    if (la) m_a = val;
    if (lb) m_b = val;
    if (clr) begin m_c = 1'b0; m_z = 1'b0; end
    #1;
    load_a = 1'b0; load_b = 1'b0; clear_flags = 1'b0;
    if (clr) check("idle_clear", {62'd0, flag_c, flag_z}, 64'd0);
  endtask

  // Request an operation and hold it until accepted; call only at posedge+1.
  task automatic issue_op(input logic [S-1:0] sel, input logic uc, input logic clr,
                          input logic la, input logic lb, input logic [W-1:0] val,
                          output int t_acc);
    exp_t e;
    logic [W+1:0] r;
    op_valid = 1'b1; op_sel = sel; use_carry = uc; clear_flags = clr;
    load_a = la; load_b = lb; bus_in = val;
    wait_ready();
    t_acc = -1;
    if (op_ready) begin
      @(posedge clk);
      if (la) m_a = val;
      if (lb) m_b = val;
      e.a = m_a; e.b = m_b; e.sel = sel; e.cin = uc & m_c;
      r = alu_fn(m_a, m_b, sel, e.cin);
      e.res = r[W-1:0]; e.c = r[W+1]; e.z = r[W];
      m_c = e.c; m_z = e.z;
      sb.push_back(e);
      #1;
      t_acc = cyc;
    end
    op_valid = 1'b0; load_a = 1'b0; load_b = 1'b0; clear_flags = 1'b0;
  endtask

  int t1, t2, t3;

  initial begin
    // Reset state.
    #2 rst_n = 1'b0;
    #1 check("reset_outputs", {6'd0, op_ready, enable, in_1, in_2, result, select, carry_in,
                               result_valid, flag_c, flag_z}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", {63'd0, op_ready}, 64'd1);
    @(posedge clk); #1;

    // Basic op: OR of 1200 and 0034.
    idle_cycle(1'b1, 1'b0, 16'h1200, 1'b0);
    issue_op(5'h03, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0034, t1);
    wait_ready();
    check("basic_result", {48'd0, result}, 64'h1234);
    @(posedge clk); #1;

    // Carry chain: FFFF + 0001 gives 0000 with carry and zero.
    idle_cycle(1'b1, 1'b1, 16'hffff, 1'b0);
    issue_op(5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0001, t1);
    issue_op(5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, t1);
    issue_op(5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, t1);

    // Busy protection: load and request during execute are ignored.
    issue_op(5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0f0f, t1);
    load_a = 1'b1; bus_in = 16'hffff; op_valid = 1'b1;
    @(negedge clk);
    check("busy_not_ready", {63'd0, op_ready}, 64'd0);
    @(posedge clk); #1;
    load_a = 1'b0;
    issue_op(5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, t2);
    check("accept_spacing", 64'(t2 - t1), 64'(Ec + 2));

    // Load together with accepted request; then clear on the capture edge.
    idle_cycle(1'b1, 1'b0, 16'hffff, 1'b0);
    issue_op(5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0001, t1);
    repeat (Ec - 1) @(posedge clk);
    #1 clear_flags = 1'b1;
    @(posedge clk);
    #1 clear_flags = 1'b0;
    wait_ready();
    check("capture_beats_clear", {62'd0, flag_c, flag_z}, 64'd3);
    @(posedge clk); #1;

    // Clear in the accept cycle: carry_in still sees the old carry.
    issue_op(5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 16'habcd, t1);
    idle_cycle(1'b0, 1'b0, 16'h0000, 1'b1);

    // Back-to-back with op_valid held.
    issue_op(5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, t1);
    issue_op(5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, t2);
    issue_op(5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, t3);
    check("b2b_spacing_1", 64'(t2 - t1), 64'(Ec + 2));
    check("b2b_spacing_2", 64'(t3 - t2), 64'(Ec + 2));

    // Randomised operations.
    for (int i = 0; i < 40; i++) begin
      logic [S-1:0] sel;
      sel = S'($urandom_range(0, 5));
      if (sel == 5'd5) sel = S'($urandom_range(5, 31));
      if ($urandom_range(0, 3) == 0)
        idle_cycle($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, W'($urandom),
                   $urandom_range(0, 4) == 0);
      issue_op(sel, $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0,
               $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, W'($urandom), t1);
    end

    // Reset mid-execute: enable drops at once and no result appears.
    idle_cycle(1'b1, 1'b1, 16'hffff, 1'b0);
    issue_op(5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, t1);
    issue_op(5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h8001, t1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check("reset_mid_exec", {6'd0, op_ready, enable, in_1, in_2, result, select, carry_in,
                                result_valid, flag_c, flag_z}, 64'd0);
    sb.delete();
    m_a = '0; m_b = '0; m_c = 1'b0; m_z = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_midreset", {62'd0, op_ready, result_valid}, 64'd2);
    @(posedge clk); #1;
    issue_op(5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 16'h00f0, t1);

    // Drain the scoreboard.
    for (int n = 0; n < 100 && sb.size() != 0; n++) @(posedge clk);
    repeat (2) @(posedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
